// File: rtl/spi_master_pkg.sv
// Shared constants for the SPI master TX path: FSM state encodings, mode
// selects and per-beat shift step sizes.
package spi_master_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE      = 2'd0;
  localparam state_t WAIT_DATA = 2'd1;
  localparam state_t SHIFT     = 2'd2;

  localparam logic SPI_STD  = 1'b0;
  localparam logic SPI_QUAD = 1'b1;

  localparam int STEP_STD  = 1;
  localparam int STEP_QUAD = 4;

endpackage

// File: rtl/spi_master_clkdiv.sv
// SCLK generator: counts clk_i cycles up to the divider setting and toggles
// SCLK at each terminal count, flagging the cycle whose edge lowers SCLK.
module spi_master_clkdiv #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 run_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 sclk_o,
  output logic                 fall_o
);

  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 tick;

  assign tick   = run_i && (div_cnt == div_i);
  assign fall_o = tick && sclk_o;

  // clear_i parks SCLK low and restarts the count so the next run begins a
  // fresh low half-period
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      div_cnt <= '0;
      sclk_o  <= 1'b0;
    end else if (run_i) begin
      if (tick) begin
        div_cnt <= '0;
        sclk_o  <= ~sclk_o;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// SPI master transmit engine: pops words from the TX FIFO and serialises them
// MSB-first on SDO in standard or quad mode under a mode-0 SCLK.
module spi_master_tx
  import spi_master_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  quad_i,
  input  logic [CNT_WIDTH-1:0]  counter_i,
  input  logic [DIV_WIDTH-1:0]  clkdiv_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  sclk_o,
  output logic [3:0]            sdo_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int WL_WIDTH = $clog2(DATA_WIDTH) + 1;

  state_t                state_q;
  logic                  quad_q;
  logic [DIV_WIDTH-1:0]  clkdiv_q;
  logic [CNT_WIDTH-1:0]  bits_left;
  logic [CNT_WIDTH-1:0]  step_bits;
  logic [CNT_WIDTH-1:0]  dec_bits;
  logic [WL_WIDTH-1:0]   word_left;
  logic [WL_WIDTH-1:0]   step_word;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_next;
  logic                  done_q;
  logic                  fall;
  logic                  last_beat;
  logic                  word_end;
  logic                  pop;
  logic                  div_run;
  logic                  div_clear;

  spi_master_clkdiv #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clkdiv (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (div_clear),
    .run_i   (div_run),
    .div_i   (clkdiv_q),
    .sclk_o  (sclk_o),
    .fall_o  (fall)
  );

  assign step_bits  = (quad_q == SPI_QUAD) ? CNT_WIDTH'(STEP_QUAD) : CNT_WIDTH'(STEP_STD);
  assign step_word  = (quad_q == SPI_QUAD) ? WL_WIDTH'(STEP_QUAD)  : WL_WIDTH'(STEP_STD);
  assign shreg_next = (quad_q == SPI_QUAD) ? (shreg << STEP_QUAD)  : (shreg << STEP_STD);

  // Clamp the decrement so a partial final quad beat drains bits_left to
  // exactly zero instead of wrapping
  assign dec_bits  = (bits_left < step_bits) ? bits_left : step_bits;
  assign last_beat = (bits_left == dec_bits);
  assign word_end  = (word_left == step_word);

  assign ready_o = (state_q == WAIT_DATA) ||
                   ((state_q == SHIFT) && fall && word_end && !last_beat);
  assign pop     = ready_o && valid_i;

  assign div_run   = (state_q == SHIFT);
  assign div_clear = (state_q != SHIFT);

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

  always_comb begin
    sdo_o = 4'b0000;
    if (state_q == SHIFT) begin
      if (quad_q == SPI_QUAD) begin
        sdo_o = shreg[DATA_WIDTH-1 -: 4];
      end else begin
        sdo_o = {3'b000, shreg[DATA_WIDTH-1]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      quad_q    <= SPI_STD;
      clkdiv_q  <= '0;
      bits_left <= '0;
      word_left <= '0;
      shreg     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en_i) begin
            if (counter_i == '0) begin
              done_q <= 1'b1;
            end else begin
              quad_q    <= quad_i ? SPI_QUAD : SPI_STD;
              clkdiv_q  <= clkdiv_i;
              bits_left <= counter_i;
              state_q   <= WAIT_DATA;
            end
          end
        end

        WAIT_DATA: begin
          if (valid_i) begin
            shreg     <= data_i;
            word_left <= WL_WIDTH'(DATA_WIDTH);
            state_q   <= SHIFT;
          end
        end

        SHIFT: begin
          if (fall) begin
            bits_left <= bits_left - dec_bits;
            if (last_beat) begin
              shreg   <= '0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else if (word_end) begin
              // Back-to-back pop keeps SCLK running; otherwise stall low
              if (pop) begin
                shreg     <= data_i;
                word_left <= WL_WIDTH'(DATA_WIDTH);
              end else begin
                shreg     <= shreg_next;
                word_left <= '0;
                state_q   <= WAIT_DATA;
              end
            end else begin
              shreg     <= shreg_next;
              word_left <= word_left - step_word;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed self-checking bench for spi_master_tx with a small TX FIFO model
// and a monitor recording SCLK rising edges, SDO samples, pops and done pulses.
module tb_spi_master_tx;

  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int DVW = 8;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           en_i;
  logic           quad_i;
  logic [CW-1:0]  counter_i;
  logic [DVW-1:0] clkdiv_i;
  logic [DW-1:0]  data_i;
  logic           valid_i;
  logic           ready_o;
  logic           sclk_o;
  logic [3:0]     sdo_o;
  logic           busy_o;
  logic           done_o;

  int testsRun  = 0;
  int failCount = 0;

  spi_master_tx #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW),
    .DIV_WIDTH  (DVW)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .quad_i    (quad_i),
    .counter_i (counter_i),
    .clkdiv_i  (clkdiv_i),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .sclk_o    (sclk_o),
    .sdo_o     (sdo_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  // TX FIFO model: the bench pushes, the DUT pops on ready && valid
  logic [DW-1:0] fifoMem [0:15];
  logic [3:0]    wrPtr;
  logic [3:0]    rdPtr = 4'd0;

  assign valid_i = (rdPtr != wrPtr);
  assign data_i  = fifoMem[rdPtr];

  always @(posedge clk_i) begin
    if (ready_o && valid_i) rdPtr <= rdPtr + 4'd1;
  end

  int         cyc         = 0;
  int         riseCount   = 0;
  int         popCount    = 0;
  int         doneCount   = 0;
  int         readyCycles = 0;
  int         doneCyc     = 0;
  logic       prevSclk    = 1'b0;
  int         riseCyc [0:255];
  logic [3:0] riseSdo [0:255];

  always @(negedge clk_i) begin
    cyc      <= cyc + 1;
    prevSclk <= sclk_o;
    if (!prevSclk && sclk_o) begin
      riseCyc[riseCount[7:0]] <= cyc;
      riseSdo[riseCount[7:0]] <= sdo_o;
      riseCount <= riseCount + 1;
    end
    if (ready_o) readyCycles <= readyCycles + 1;
    if (ready_o && valid_i) popCount <= popCount + 1;
    if (done_o) begin
      doneCount <= doneCount + 1;
      doneCyc   <= cyc;
    end
  end

  function automatic int riseAt(input int i);
    return riseCyc[i[7:0]];
  endfunction

  function automatic logic [63:0] collectBits(input int base, input int n, input logic quad);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = base + i;
      if (quad) r = {r[59:0], riseSdo[idx[7:0]]};
      else      r = {r[62:0], riseSdo[idx[7:0]][0]};
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic q, input int cnt, input int div);
    quad_i    = q;
    counter_i = cnt[CW-1:0];
    clkdiv_i  = div[DVW-1:0];
    en_i      = 1'b1;
    @(negedge clk_i);
    en_i      = 1'b0;
  endtask

  task automatic pushWord(input logic [DW-1:0] w);
    fifoMem[wrPtr] = w;
    wrPtr = wrPtr + 4'd1;
  endtask

  task automatic waitRises(input int base, input int n, input int budget);
    int k;
    k = 0;
    while ((riseCount - base) < n && k < budget) begin
      @(negedge clk_i);
      k++;
    end
  endtask

  task automatic waitDone(input string tag, input int base, input int budget);
    int k;
    k = 0;
    while (doneCount == base && k < budget) begin
      @(negedge clk_i);
      k++;
    end
    checkOutput(tag, 64'(doneCount - base), 64'd1);
    checkOutput({tag, " pulse width"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    int b;
    int bp;
    int bd;
    int br;

    rst_i     = 1'b1;
    en_i      = 1'b0;
    quad_i    = 1'b0;
    counter_i = '0;
    clkdiv_i  = '0;
    wrPtr     = 4'd0;
    repeat (3) @(negedge clk_i);
    checkOutput("reset sclk",  64'(sclk_o),  64'd0);
    checkOutput("reset sdo",   64'(sdo_o),   64'd0);
    checkOutput("reset busy",  64'(busy_o),  64'd0);
    checkOutput("reset ready", 64'(ready_o), 64'd0);
    checkOutput("reset done",  64'(done_o),  64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // std, 8 bits of 0xA5, divider 0
    pushWord(32'hA500_0000);
    b = riseCount; bp = popCount; bd = doneCount;
    applyStimulus(1'b0, 8, 0);
    waitDone("t1 done", bd, 200);
    checkOutput("t1 rises",  64'(riseCount - b), 64'd8);
    checkOutput("t1 bits",   collectBits(b, 8, 1'b0), 64'hA5);
    checkOutput("t1 pops",   64'(popCount - bp), 64'd1);
    checkOutput("t1 period", 64'(riseAt(b + 7) - riseAt(b)), 64'd14);
    checkOutput("t1 done lag", 64'(doneCyc - riseAt(b + 7)), 64'd1);
    checkOutput("t1 busy",   64'(busy_o), 64'd0);

    // std, 64 bits over two pre-filled words, no SCLK gap
    pushWord(32'hDEAD_BEEF);
    pushWord(32'h0123_4567);
    b = riseCount; bp = popCount; bd = doneCount; br = readyCycles;
    applyStimulus(1'b0, 64, 0);
    waitDone("t2 done", bd, 400);
    checkOutput("t2 rises",  64'(riseCount - b), 64'd64);
    checkOutput("t2 bits",   collectBits(b, 64, 1'b0), 64'hDEAD_BEEF_0123_4567);
    checkOutput("t2 pops",   64'(popCount - bp), 64'd2);
    checkOutput("t2 ready cycles", 64'(readyCycles - br), 64'd2);
    checkOutput("t2 contiguous", 64'(riseAt(b + 63) - riseAt(b)), 64'd126);

    // quad, 32 bits, divider 1
    pushWord(32'h1234_5678);
    b = riseCount; bp = popCount; bd = doneCount;
    applyStimulus(1'b1, 32, 1);
    waitDone("t3 done", bd, 300);
    checkOutput("t3 rises",  64'(riseCount - b), 64'd8);
    checkOutput("t3 nibbles", collectBits(b, 8, 1'b1), 64'h1234_5678);
    checkOutput("t3 period", 64'(riseAt(b + 7) - riseAt(b)), 64'd28);
    checkOutput("t3 done lag", 64'(doneCyc - riseAt(b + 7)), 64'd2);
    checkOutput("t3 pops",   64'(popCount - bp), 64'd1);

    // std, 40 bits, second word arrives late
    pushWord(32'h0F0F_3C3C);
    b = riseCount; bp = popCount; bd = doneCount;
    applyStimulus(1'b0, 40, 0);
    waitRises(b, 32, 200);
    repeat (3) @(negedge clk_i);
    checkOutput("t4 stall sclk",  64'(sclk_o),  64'd0);
    checkOutput("t4 stall ready", 64'(ready_o), 64'd1);
    checkOutput("t4 stall busy",  64'(busy_o),  64'd1);
    checkOutput("t4 stall pops",  64'(popCount - bp), 64'd1);
    repeat (7) @(negedge clk_i);
    pushWord(32'h96FF_FFFF);
    waitDone("t4 done", bd, 300);
    checkOutput("t4 rises", 64'(riseCount - b), 64'd40);
    checkOutput("t4 bits",  collectBits(b, 40, 1'b0), 64'h0F_0F3C_3C96);
    checkOutput("t4 pops",  64'(popCount - bp), 64'd2);

    // zero-length transfer
    bp = popCount; bd = doneCount;
    applyStimulus(1'b0, 0, 0);
    checkOutput("t5 done",  64'(done_o), 64'd1);
    checkOutput("t5 busy",  64'(busy_o), 64'd0);
    checkOutput("t5 sclk",  64'(sclk_o), 64'd0);
    @(negedge clk_i);
    checkOutput("t5 done width", 64'(done_o), 64'd0);
    checkOutput("t5 ready", 64'(ready_o), 64'd0);
    checkOutput("t5 pops",  64'(popCount - bp), 64'd0);

    // reset in the middle of a word
    pushWord(32'hAAAA_5555);
    b = riseCount; bp = popCount; bd = doneCount;
    applyStimulus(1'b0, 32, 0);
    waitRises(b, 5, 100);
    checkOutput("t6 rises before reset", 64'(riseCount - b), 64'd5);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("t6 sclk",  64'(sclk_o),  64'd0);
    checkOutput("t6 busy",  64'(busy_o),  64'd0);
    checkOutput("t6 ready", 64'(ready_o), 64'd0);
    checkOutput("t6 done",  64'(done_o),  64'd0);
    rst_i = 1'b0;
    repeat (5) @(negedge clk_i);
    checkOutput("t6 no done", 64'(doneCount - bd), 64'd0);
    checkOutput("t6 pops",    64'(popCount - bp), 64'd1);
    checkOutput("t6 idle",    64'(busy_o), 64'd0);

    // en_i while busy must not disturb the running transfer
    pushWord(32'hC3A5_0000);
    b = riseCount; bp = popCount; bd = doneCount;
    applyStimulus(1'b0, 16, 1);
    waitRises(b, 4, 100);
    quad_i    = 1'b1;
    counter_i = 16'd4;
    clkdiv_i  = 8'd0;
    en_i      = 1'b1;
    @(negedge clk_i);
    en_i = 1'b0;
    waitDone("t7 done", bd, 300);
    checkOutput("t7 rises",  64'(riseCount - b), 64'd16);
    checkOutput("t7 bits",   collectBits(b, 16, 1'b0), 64'hC3A5);
    checkOutput("t7 period", 64'(riseAt(b + 15) - riseAt(b)), 64'd60);
    checkOutput("t7 pops",   64'(popCount - bp), 64'd1);
    repeat (3) @(negedge clk_i);
    checkOutput("t7 idle after", 64'(busy_o), 64'd0);
    checkOutput("t7 single done", 64'(doneCount - bd), 64'd1);
    checkOutput("fifo drained", 64'(rdPtr), 64'(wrPtr));

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
Transmit shift engine of the APB SPI master. It sits directly downstream of the TX FIFO and pops 32-bit words over a valid/ready handshake. Each word is serialised MSB-first onto SDO in standard (1-bit) or quad (4-bit) mode, and the block generates SCLK (mode 0) from a programmable divider. A transfer of counter_i bits spans as many FIFO words as needed; SCLK stalls low when the FIFO runs dry.

Parameters:
DATA_WIDTH, 32, width of one FIFO word / shift register
CNT_WIDTH, 16, width of the transfer bit counter
DIV_WIDTH, 8, width of the SCLK divider setting

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, synchronous active-high
en_i  in  1  start pulse; sampled only in IDLE
quad_i  in  1  1 = quad (4 bits/SCLK), 0 = standard (1 bit/SCLK); latched at start
counter_i  in  CNT_WIDTH  bits to transmit; latched at start
clkdiv_i  in  DIV_WIDTH  SCLK half-period in clk_i cycles, minus 1; latched at start
data_i  in  DATA_WIDTH  word from TX FIFO data_o
valid_i  in  1  TX FIFO valid_o
ready_o  out  1  to TX FIFO ready_i; a pop occurs when ready_o && valid_i
sclk_o  out  1  SPI clock, idle low
sdo_o  out  4  serial data; standard mode uses [0], [3:1] = 0
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle pulse at transfer end

Behaviour:
- Reset (sync, rst_i=1 at a clk_i edge): state=IDLE. All outputs 0. Counters and shift register cleared. Reset mid-transfer aborts the transfer: sclk_o=0 and busy_o=0 the next cycle, no done_o, no further pops.
- States: IDLE, WAIT_DATA, SHIFT.
- IDLE: sdo_o=0, sclk_o=0, ready_o=0.
  - On en_i with counter_i!=0: latch quad_i/clkdiv_i, set bits_left=counter_i, go WAIT_DATA.
  - On en_i with counter_i==0: pulse done_o next cycle, stay IDLE.
  - en_i outside IDLE is ignored.
- WAIT_DATA: ready_o=1, sclk_o held 0.
  - On valid_i: shreg<=data_i, word_left<=DATA_WIDTH, div_cnt<=0, go SHIFT.
- SHIFT, divider:
  - div_cnt counts 0..clkdiv; at terminal count it wraps to 0 and sclk_o toggles.
  - SCLK period = 2*(clkdiv+1) clk_i cycles. First rising edge occurs clkdiv+1 cycles after load.
- SHIFT, output and shifting:
  - sdo_o = {3'b0, shreg[MSB]} (std) or shreg[MSB:MSB-3] (quad). Valid from load, changes only on falling edges.
  - On each falling-edge toggle: shreg shifts left by step (1 or 4); bits_left -= min(step, bits_left); word_left -= step.
- Transfer end: when bits_left reaches 0 on a falling edge, sclk_o=0, done_o pulses the next cycle, go IDLE. Unused tail bits of the last word are discarded and there is no extra pop. A quad counter_i that is not a multiple of 4 ends after the beat containing the last bit.
- Word boundary: when word_left reaches 0 and bits_left>0 on a falling edge, ready_o=1 that same cycle.
  - If valid_i: load the next word with no SCLK gap.
  - Else: go WAIT_DATA (stall, SCLK low), then resume with div_cnt=0.
- ready_o is asserted only in WAIT_DATA and on the word-boundary cycle. Never more than one pop per word.
- Width rules: bits_left is CNT_WIDTH bits and never underflows. word_left is log2(DATA_WIDTH)+1 bits.

Decomposition:
- Package spi_master_pkg holds:
  - state enum (IDLE, WAIT_DATA, SHIFT)
  - mode constants (SPI_STD=0, SPI_QUAD=1)
  - step sizes (1, 4)
- One sub-module is natural: spi_master_clkdiv (div_cnt, sclk toggle, rise/fall strobes, sync clear).

Test Plan:
- Std, counter_i=8, clkdiv=0, FIFO holds 0xA5000000 -> 8 SCLK pulses of period 2 cycles; sdo_o[0]=1,0,1,0,0,1,0,1; exactly 1 pop; done_o one cycle after the 8th falling edge.
- Std, counter_i=64, two words pre-filled -> 64 contiguous SCLK pulses with no gap; 2 pops; ready_o single-cycle pulse at the bit-32 falling edge.
- Quad, counter_i=32, clkdiv=1, word 0x12345678 -> sdo_o nibbles 1,2,...,8; 8 SCLK periods of 4 cycles each; done_o.
- Std, counter_i=40, second word arrives 10 cycles late -> SCLK low and ready_o=1 during the stall; 40 rising edges total; 2 pops; bits 40..63 of word 2 unsent.
- counter_i=0 with en_i -> done_o pulse, busy_o stays 0, no pop, sclk_o=0.
- rst_i asserted mid-word; separately en_i pulsed while busy -> after reset sclk_o/busy_o/ready_o=0 next cycle with no done_o; the en_i while busy has no effect on the ongoing transfer.
